// File: rtl/rand_range_sampler_if.sv
// Request/result handshake bundle for rand_range_sampler.
// The master side issues requests and consumes results; the slave side is the sampler.
interface rand_range_sampler_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] limit;
    logic             req_valid;
    logic             req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_fallback;

    modport master (
        output limit,
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_value,
        input  out_fallback
    );

    modport slave (
        input  limit,
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_value,
        output out_fallback
    );
endinterface

// File: rtl/rand_range_sampler.sv
// Bounded masked rejection sampler: maps a free-running LFSR stream onto [0, limit-1].
// Define RANGE_STATS_EN to add saturating rejection/fallback counters (rej_total, fallback_total).
module rand_range_sampler #(
    parameter int WIDTH      = 8,
    parameter int MAX_REJECT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] random_in,
    rand_range_sampler_if.slave bus
`ifdef RANGE_STATS_EN
    ,
    output logic [15:0]      rej_total,
    output logic [7:0]       fallback_total
`endif
);

    localparam int CW = $clog2(MAX_REJECT + 1);
    localparam logic [CW-1:0] LAST_TRY = CW'(MAX_REJECT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] limit_reg, limit_next;
    logic [WIDTH-1:0] mask_reg, mask_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] value_reg, value_next;
    logic             fb_reg, fb_next;

    logic [WIDTH-1:0] limit_m1;
    logic [WIDTH-1:0] mask_calc;
    logic [WIDTH-1:0] cand;
    logic             accept;

    // Mask bit gi is set when any bit at or above gi is set in limit-1, giving the
    // smallest 2^k-1 covering limit-1. limit==0 wraps to all-ones (full range).
    assign limit_m1 = bus.limit - WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mask
            assign mask_calc[gi] = |limit_m1[WIDTH-1:gi];
        end
    endgenerate

    assign cand   = random_in & mask_reg;
    assign accept = (limit_reg == '0) || (cand < limit_reg);

    // Gated by reset so ready is low while reset is held and high as soon as it lifts.
    assign bus.req_ready    = (state_reg == IDLE) && reset;
    assign bus.out_valid    = (state_reg == HOLD);
    assign bus.out_value    = value_reg;
    assign bus.out_fallback = fb_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            limit_reg <= '0;
            mask_reg  <= '0;
            cnt_reg   <= '0;
            value_reg <= '0;
            fb_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            limit_reg <= limit_next;
            mask_reg  <= mask_next;
            cnt_reg   <= cnt_next;
            value_reg <= value_next;
            fb_reg    <= fb_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        limit_next = limit_reg;
        mask_next  = mask_reg;
        cnt_next   = cnt_reg;
        value_next = value_reg;
        fb_next    = fb_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    limit_next = bus.limit;
                    mask_next  = mask_calc;
                    cnt_next   = '0;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (accept) begin
                    value_next = cand;
                    fb_next    = 1'b0;
                    state_next = HOLD;
                end else if (cnt_reg == LAST_TRY) begin
                    // Dropping the top mask bit keeps the value below limit-1.
                    value_next = cand & (mask_reg >> 1);
                    fb_next    = 1'b1;
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RANGE_STATS_EN
    logic        reject_evt;
    logic        fallback_evt;
    logic [15:0] rej_total_reg;
    logic [7:0]  fallback_total_reg;

    assign reject_evt   = (state_reg == SAMPLE) && !accept;
    assign fallback_evt = reject_evt && (cnt_reg == LAST_TRY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rej_total_reg      <= '0;
            fallback_total_reg <= '0;
        end else begin
            if (reject_evt && (rej_total_reg != 16'hFFFF)) begin
                rej_total_reg <= rej_total_reg + 16'd1;
            end
            if (fallback_evt && (fallback_total_reg != 8'hFF)) begin
                fallback_total_reg <= fallback_total_reg + 8'd1;
            end
        end
    end

    assign rej_total      = rej_total_reg;
    assign fallback_total = fallback_total_reg;
`endif

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Downstream consumer of the free-running 8-bit LFSR output.
- On request, turns the raw pseudo-random stream into a uniformly distributed value in [0, limit-1] by masked rejection sampling.
- Delivers the result over a valid/ready handshake to game/test logic. The retry count is bounded so latency stays deterministic.

Parameters:
- WIDTH, 8: width of random_in, limit and out_value.
- MAX_REJECT, 15: rejections allowed per request before fallback; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising clk edge resets the block.
- random_in  in  WIDTH  LFSR output; a new value is presented every cycle.
- limit  in  WIDTH  range size N; 0 means 2^WIDTH. Sampled on request handshake.
- req_valid  in  1  request strobe.
- req_ready  out  1  block can accept a request.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_value  out  WIDTH  sampled value, always < N.
- out_fallback  out  1  result came from the fallback path, not a clean accept.

Behaviour:
- Reset (reset==0): state=IDLE; req_ready=0 during reset, 1 on the first cycle after; out_valid=0; out_value=0; out_fallback=0; reject_cnt=0; limit_q=0; mask_q=0.
- FSM states: IDLE, SAMPLE, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: limit_q<=limit; mask_q<=smallest (2^k-1) >= limit-1 (for limit 0 or 1: all-ones or 0 respectively); reject_cnt<=0; go to SAMPLE.
- SAMPLE:
  - req_ready=0.
  - cand = random_in & mask_q.
  - Accept if limit_q==0 or cand < limit_q: out_value<=cand, out_fallback<=0, go to HOLD.
  - Otherwise reject. If reject_cnt==MAX_REJECT-1: out_value<=cand & (mask_q>>1), out_fallback<=1, go to HOLD. Else reject_cnt++ and stay in SAMPLE.
- HOLD:
  - out_valid=1; out_value and out_fallback stable.
  - On out_ready: out_valid<=0, go to IDLE.
- Handshake rules:
  - req_ready is never 1 outside IDLE.
  - A req_valid/out_ready pair in the same cycle cannot complete both; the new request is accepted on the next IDLE cycle.
- Latency: request handshake at edge T; first sample evaluated in cycle T+1; out_valid high from T+2 on a clean first accept; +1 cycle per rejection; worst case T+1+MAX_REJECT.
- limit==1: mask 0, cand 0, always accepted first try.
- limit==0: full range; every sample accepted; out_value=random_in.
- Fallback value is guaranteed < N, since mask_q>>1 < N-1.
- reject_cnt width: clog2(MAX_REJECT+1). The comparator is unsigned and WIDTH bits wide.
- reset low mid-SAMPLE or mid-HOLD: pending request and result are discarded; all outputs return to reset values at that edge.
- random_in is only used in SAMPLE; its value in other states is ignored.

Optional Feature:
- Macro: RANGE_STATS_EN.
- Defined: adds output rej_total [15:0], a saturating count of all rejections since reset (holds at 16'hFFFF), plus output fallback_total [7:0], a saturating count of fallback results. Both are cleared by reset.
- Undefined: neither port exists and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Accept after reject: limit=10 (mask 15), random_in sequence 0x3C then 0x07 -> first sample 12 rejected, second sample accepted; out_value=7, out_fallback=0, out_valid rises at T+3.
- Full range and unit range: limit=0 with random_in=0xA5 -> out_value=0xA5 at T+2. limit=1 with random_in=0xFF -> out_value=0 at T+2.
- Fallback: MAX_REJECT=15, limit=9, random_in held at 0x0F -> 15 rejections, then out_value=0x07, out_fallback=1, out_valid at T+16. With RANGE_STATS_EN defined, rej_total=15 and fallback_total=1.
- Backpressure: out_ready held low for 5 cycles in HOLD -> out_valid stays 1, out_value stays stable, and req_ready stays 0 while req_valid=1. On out_ready=1, the block returns to IDLE and accepts the pending request the next cycle.
- Reset mid-operation: reset=0 for one cycle during SAMPLE (limit=9, random_in=0x0F) -> on the following cycle state=IDLE, out_valid=0, out_value=0, req_ready=1; a new request with limit=4 and random_in=0x02 completes with out_value=2.
